// File: rtl/cmp_pkg.sv
// cmp_pkg: shared types and helpers for the comparator trend monitor.
//   trend_t  - FSM state, output directly on the trend port
//   class_t  - classification of one comparator sample
//   sat_inc  - saturating increment on a 32-bit container
//   max_of   - all-ones value for a given width (width <= 32)
package cmp_pkg;

    typedef enum logic [1:0] {
        Idle  = 2'd0,
        EqRun = 2'd1,
        GtRun = 2'd2,
        LtRun = 2'd3
    } trend_t;

    // Class codes mirror the run-state codes so a class casts straight onto its run state.
    typedef enum logic [1:0] {
        ClsNone = 2'd0,
        ClsEq   = 2'd1,
        ClsGt   = 2'd2,
        ClsLt   = 2'd3
    } class_t;

    function automatic logic [31:0] max_of(input int unsigned width);
        return (width >= 32) ? 32'hffff_ffff : ((32'd1 << width) - 32'd1);
    endfunction

    function automatic logic [31:0] sat_inc(input logic [31:0] val, input logic [31:0] max);
        return (val >= max) ? val : val + 32'd1;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// sat_counter: up-counter that saturates at all-ones.
// Parameters: WIDTH - counter width (1..32).
// Ports:
//   clk   - clock, rising edge
//   rst_n - asynchronous active-low reset
//   clr   - synchronous clear, wins over inc
//   inc   - count one event
//   count - current value
module sat_counter
    import cmp_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    localparam logic [31:0] Max = max_of(WIDTH);

    logic [WIDTH-1:0] count_d, count_q;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc) begin
            count_d = WIDTH'(sat_inc(32'(count_q), Max));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/cmp_trend_monitor.sv
// cmp_trend_monitor: classifies registered comparator results into runs.
// Keeps saturating per-outcome counters, the current run length, and pulses
// alert for one cycle when a run first reaches RUN_THRESH.
// Build option: define CMP_TREND_CHECK_EN to reject samples whose flags are not
// one-hot or disagree with a recompare of a/b (sets sticky err). Without it,
// err is 0, a/b are unused and the class is taken by priority equal>greater>less.
// Ports:
//   clk, rst_n                 - clock, asynchronous active-low reset
//   clear                      - synchronous clear, beats in_valid
//   in_valid, a, b             - sample qualifier and operands
//   equal, greater, less       - comparator flags
//   eq_count/gt_count/lt_count - saturating outcome counters
//   run_len                    - current run length (saturating)
//   trend                      - FSM state (0 idle, 1 eq, 2 gt, 3 lt)
//   alert                      - one-cycle pulse on reaching RUN_THRESH
//   err                        - sticky rejected-sample flag
module cmp_trend_monitor
    import cmp_pkg::*;
#(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned CNT_W      = 16,
    parameter int unsigned RUN_W      = 8,
    parameter int unsigned RUN_THRESH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              equal,
    input  logic              greater,
    input  logic              less,
    output logic [CNT_W-1:0]  eq_count,
    output logic [CNT_W-1:0]  gt_count,
    output logic [CNT_W-1:0]  lt_count,
    output logic [RUN_W-1:0]  run_len,
    output logic [1:0]        trend,
    output logic              alert,
    output logic              err
);

    localparam logic [31:0]      RunMax = max_of(RUN_W);
    localparam logic [RUN_W-1:0] RunPre = RUN_W'(RUN_THRESH - 1);

    trend_t           state_q, state_d;
    logic [RUN_W-1:0] run_q, run_d;
    logic             alert_q, alert_d;
    class_t           cls;
    logic             reject;
    logic             accept;

    always_comb begin
        cls = ClsNone;
        if (equal) begin
            cls = ClsEq;
        end else if (greater) begin
            cls = ClsGt;
        end else if (less) begin
            cls = ClsLt;
        end
    end

`ifdef CMP_TREND_CHECK_EN
    logic one_hot, agree, err_d, err_q;

    always_comb begin
        one_hot = (equal ^ greater ^ less) && !(equal && greater && less);
        agree   = (equal && (a == b)) || (greater && (a > b)) || (less && (a < b));
        reject  = in_valid && !(one_hot && agree);
        err_d   = err_q;
        if (clear) begin
            err_d = 1'b0;
        end else if (reject) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err = err_q;
`else
    logic unused_ab;
    assign unused_ab = ^{a, b};
    assign reject    = 1'b0;
    assign err       = 1'b0;
`endif

    // Dropped when clear is high: clear alone decides the next state then.
    assign accept = in_valid && !clear && !reject && (cls != ClsNone);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= Idle;
            run_q   <= '0;
            alert_q <= 1'b0;
        end else begin
            state_q <= state_d;
            run_q   <= run_d;
            alert_q <= alert_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        run_d   = run_q;
        alert_d = 1'b0;
        if (clear) begin
            state_d = Idle;
            run_d   = '0;
        end else if (accept) begin
            if (state_q != Idle && trend_t'(cls) == state_q) begin
                run_d = RUN_W'(sat_inc(32'(run_q), RunMax));
                // Only the step THRESH-1 -> THRESH fires; saturation cannot revisit it.
                alert_d = (run_q == RunPre);
            end else begin
                state_d = trend_t'(cls);
                run_d   = RUN_W'(1);
            end
        end
    end

    // Outputs.
    always_comb begin
        trend   = state_q;
        run_len = run_q;
        alert   = alert_q;
    end

    sat_counter #(.WIDTH(CNT_W)) u_eq_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clear),
        .inc   (accept && cls == ClsEq),
        .count (eq_count)
    );

    sat_counter #(.WIDTH(CNT_W)) u_gt_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clear),
        .inc   (accept && cls == ClsGt),
        .count (gt_count)
    );

    sat_counter #(.WIDTH(CNT_W)) u_lt_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clear),
        .inc   (accept && cls == ClsLt),
        .count (lt_count)
    );

endmodule

// File: tb/tb_cmp_trend_monitor.sv
// Scoreboard bench: stimulus pushes hand-computed expectations tagged with the
// cycle they become visible; a negedge monitor pops and compares them.
// Instance u_dut uses defaults; u_sat uses RUN_W=3 for the saturation case.
module tb_cmp_trend_monitor;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       clear = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] a = '0;
    logic [7:0] b = '0;
    logic       equal = 1'b0;
    logic       greater = 1'b0;
    logic       less = 1'b0;

    logic [15:0] eq_count, gt_count, lt_count;
    logic [7:0]  run_len;
    logic [1:0]  trend;
    logic        alert, err;

    logic [15:0] eq_count2, gt_count2, lt_count2;
    logic [2:0]  run_len2;
    logic [1:0]  trend2;
    logic        alert2, err2;

    always #5 clk = ~clk;

    cmp_trend_monitor u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (clear),
        .in_valid (in_valid),
        .a        (a),
        .b        (b),
        .equal    (equal),
        .greater  (greater),
        .less     (less),
        .eq_count (eq_count),
        .gt_count (gt_count),
        .lt_count (lt_count),
        .run_len  (run_len),
        .trend    (trend),
        .alert    (alert),
        .err      (err)
    );

    cmp_trend_monitor #(.RUN_W(3)) u_sat (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (clear),
        .in_valid (in_valid),
        .a        (a),
        .b        (b),
        .equal    (equal),
        .greater  (greater),
        .less     (less),
        .eq_count (eq_count2),
        .gt_count (gt_count2),
        .lt_count (lt_count2),
        .run_len  (run_len2),
        .trend    (trend2),
        .alert    (alert2),
        .err      (err2)
    );

    typedef struct {
        string tag;
        int    due;
        int    eq, gt, lt, run, tr, al, er;
        bit    c2;
        int    run2;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        while (q.size() > 0 && q[0].due <= cyc) begin
            exp_t e;
            e = q.pop_front();
            chk({e.tag, ".eq_count"}, int'(eq_count), e.eq);
            chk({e.tag, ".gt_count"}, int'(gt_count), e.gt);
            chk({e.tag, ".lt_count"}, int'(lt_count), e.lt);
            chk({e.tag, ".run_len"}, int'(run_len), e.run);
            chk({e.tag, ".trend"}, int'(trend), e.tr);
            chk({e.tag, ".alert"}, int'(alert), e.al);
            chk({e.tag, ".err"}, int'(err), e.er);
            if (e.c2) begin
                chk({e.tag, ".sat.eq_count"}, int'(eq_count2), e.eq);
                chk({e.tag, ".sat.run_len"}, int'(run_len2), e.run2);
                chk({e.tag, ".sat.trend"}, int'(trend2), e.tr);
                chk({e.tag, ".sat.alert"}, int'(alert2), e.al);
            end
        end
    end

    // Called at a negedge; returns at the following negedge.
    task automatic step(input string tag, input logic c, v, e, g, l,
                        input logic [7:0] av, bv,
                        input int xeq, xgt, xlt, xrun, xtr, xal, xer,
                        input bit c2, input int xrun2);
        exp_t x;
        clear = c; in_valid = v; equal = e; greater = g; less = l; a = av; b = bv;
        x.tag = tag; x.due = cyc + 1;
        x.eq = xeq; x.gt = xgt; x.lt = xlt; x.run = xrun; x.tr = xtr; x.al = xal; x.er = xer;
        x.c2 = c2; x.run2 = xrun2;
        q.push_back(x);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
        if (q.size() > 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s.drain: got %0d pending, expected 0", tag, q.size());
            q.delete();
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".eq_count"}, int'(eq_count), 0);
        chk({tag, ".gt_count"}, int'(gt_count), 0);
        chk({tag, ".lt_count"}, int'(lt_count), 0);
        chk({tag, ".run_len"}, int'(run_len), 0);
        chk({tag, ".trend"}, int'(trend), 0);
        chk({tag, ".alert"}, int'(alert), 0);
        chk({tag, ".err"}, int'(err), 0);
        chk({tag, ".sat.run_len"}, int'(run_len2), 0);
        chk({tag, ".sat.gt_count"}, int'(gt_count2), 0);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Five GT samples; alert after the fourth only.
        step("gt1", 0, 1, 0, 1, 0, 200, 100, 0, 1, 0, 1, 2, 0, 0, 0, 0);
        step("gt2", 0, 1, 0, 1, 0, 200, 100, 0, 2, 0, 2, 2, 0, 0, 0, 0);
        step("gt3", 0, 1, 0, 1, 0, 200, 100, 0, 3, 0, 3, 2, 0, 0, 0, 0);
        step("gt4", 0, 1, 0, 1, 0, 200, 100, 0, 4, 0, 4, 2, 1, 0, 0, 0);
        step("gt5", 0, 1, 0, 1, 0, 200, 100, 0, 5, 0, 5, 2, 0, 0, 0, 0);
        step("idle", 0, 0, 0, 1, 0, 200, 100, 0, 5, 0, 5, 2, 0, 0, 0, 0);

        // Run break.
        step("clr1", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step("brk_gt1", 0, 1, 0, 1, 0, 200, 100, 0, 1, 0, 1, 2, 0, 0, 0, 0);
        step("brk_gt2", 0, 1, 0, 1, 0, 200, 100, 0, 2, 0, 2, 2, 0, 0, 0, 0);
        step("brk_lt", 0, 1, 0, 0, 1, 5, 50, 0, 2, 1, 1, 3, 0, 0, 0, 0);
        step("brk_eq", 0, 1, 1, 0, 0, 25, 25, 1, 2, 1, 1, 1, 0, 0, 0, 0);

        // Clear beats a simultaneous valid sample.
        step("clr_vld", 1, 1, 1, 0, 0, 9, 9, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Input check.
        step("chk_pre", 0, 1, 1, 0, 0, 25, 25, 1, 0, 0, 1, 1, 0, 0, 0, 0);
`ifdef CMP_TREND_CHECK_EN
        step("chk_bad", 0, 1, 1, 0, 0, 127, 128, 1, 0, 0, 1, 1, 0, 1, 0, 0);
        step("chk_multi", 0, 1, 1, 1, 0, 3, 3, 1, 0, 0, 1, 1, 0, 1, 0, 0);
        step("chk_none", 0, 1, 0, 0, 0, 5, 5, 1, 0, 0, 1, 1, 0, 1, 0, 0);
`else
        step("chk_bad", 0, 1, 1, 0, 0, 127, 128, 2, 0, 0, 2, 1, 0, 0, 0, 0);
        step("chk_multi", 0, 1, 1, 1, 0, 3, 3, 3, 0, 0, 3, 1, 0, 0, 0, 0);
        step("chk_none", 0, 1, 0, 0, 0, 5, 5, 3, 0, 0, 3, 1, 0, 0, 0, 0);
`endif
        step("clr2", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Saturation: u_sat run_len caps at 7, alert once on both.
        for (int k = 1; k <= 9; k++) begin
            step($sformatf("sat%0d", k), 0, 1, 1, 0, 0, 7, 7,
                 k, 0, 0, k, 1, (k == 4) ? 1 : 0, 0, 1, (k > 7) ? 7 : k);
        end
        step("sat_idle", 0, 0, 0, 0, 0, 7, 7, 9, 0, 0, 9, 1, 0, 0, 1, 7);

        // Asynchronous reset mid-run.
        step("clr3", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step("rg1", 0, 1, 0, 1, 0, 200, 100, 0, 1, 0, 1, 2, 0, 0, 0, 0);
        step("rg2", 0, 1, 0, 1, 0, 200, 100, 0, 2, 0, 2, 2, 0, 0, 0, 0);
        step("rg3", 0, 1, 0, 1, 0, 200, 100, 0, 3, 0, 3, 2, 0, 0, 1, 3);
        in_valid = 1'b0;
        drain("pre_rst");
        #2 rst_n = 1'b0;
        #1 chk_zero("mid_rst");
        @(negedge clk);
        rst_n = 1'b1;
        step("post_rst", 0, 1, 1, 0, 0, 25, 25, 1, 0, 0, 1, 1, 0, 0, 1, 1);
        in_valid = 1'b0;
        drain("end");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
